// File: rtl/sram_controller.sv
// 32-bit word access to a 16-bit SRAM as two halfword beats, WAIT_CYCLES each; ready drops while busy.
// Optional stall counter output under `ifdef SRAM_STALL_CNT_EN.
module sram_controller #(
  parameter int DATA_LEN      = 32,
  parameter int SRAM_ADDR_LEN = 18,
  parameter int SRAM_DATA_LEN = 16,
  parameter int WAIT_CYCLES   = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mem_read,
  input  logic                     mem_write,
  input  logic [DATA_LEN-1:0]      address,
  input  logic [DATA_LEN-1:0]      write_data,
  output logic [DATA_LEN-1:0]      read_data,
  output logic                     ready,
  output logic [SRAM_ADDR_LEN-1:0] sram_addr,
  output logic [SRAM_DATA_LEN-1:0] sram_dq_out,
  input  logic [SRAM_DATA_LEN-1:0] sram_dq_in,
  output logic                     sram_dq_oe,
  output logic                     sram_we_n
`ifdef SRAM_STALL_CNT_EN
  ,
  output logic [31:0]              stall_count
`endif
);

  localparam int CW = $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t                     state, state_nxt;
  logic [CW-1:0]              cnt;
  logic                       op_wr;
  logic [SRAM_ADDR_LEN-2:0]   word_addr;
  logic [SRAM_DATA_LEN-1:0]   wdata_hi;
  logic                       req;
  logic                       in_beat;
  logic                       beat_last;
  logic                       unused_addr;

  assign unused_addr = ^{address[DATA_LEN-1:SRAM_ADDR_LEN+1], address[1:0]};

  assign req       = mem_read | mem_write;
  assign in_beat   = (state == LOW) || (state == HIGH);
  assign beat_last = (cnt == LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = LOW;
      LOW:     if (beat_last) state_nxt = HIGH;
      HIGH:    if (beat_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign ready      = ((state == IDLE) && !req) || (state == DONE);
  assign sram_dq_oe = in_beat && op_wr;
  // Strobe released in the final cycle of each beat to give data hold.
  assign sram_we_n  = !(in_beat && op_wr && !beat_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      op_wr       <= 1'b0;
      word_addr   <= '0;
      wdata_hi    <= '0;
      read_data   <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (state_nxt != state || !in_beat) ? '0 : cnt + 1'b1;
      case (state)
        IDLE: begin
          if (req) begin
            op_wr       <= mem_write;
            word_addr   <= address[SRAM_ADDR_LEN:2];
            wdata_hi    <= write_data[DATA_LEN-1:SRAM_DATA_LEN];
            sram_addr   <= {address[SRAM_ADDR_LEN:2], 1'b0};
            sram_dq_out <= write_data[SRAM_DATA_LEN-1:0];
          end
        end
        LOW: begin
          if (beat_last) begin
            if (!op_wr) read_data[SRAM_DATA_LEN-1:0] <= sram_dq_in;
            sram_addr   <= {word_addr, 1'b1};
            sram_dq_out <= wdata_hi;
          end
        end
        HIGH: begin
          if (beat_last && !op_wr) read_data[DATA_LEN-1:SRAM_DATA_LEN] <= sram_dq_in;
        end
        default: ;
      endcase
    end
  end

`ifdef SRAM_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
    end else if (!ready && stall_count != 32'hFFFF_FFFF) begin
      stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: word-level reference map against an SRAM model that commits on the hold cycle.
module tb_sram_controller;
  localparam int W = 5;
  localparam int LAT = 2 * W + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic [15:0] sram_dq_in;
  logic        sram_dq_oe;
  logic        sram_we_n;
`ifdef SRAM_STALL_CNT_EN
  logic [31:0] stall_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] mem [0:262143];
  int          we_cnt [0:262143];
  logic [31:0] ref_word [int];
  logic        pend = 1'b0;

  sram_controller #(.DATA_LEN(32), .SRAM_ADDR_LEN(18), .SRAM_DATA_LEN(16), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .address(address), .write_data(write_data), .read_data(read_data), .ready(ready),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
    .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
`ifdef SRAM_STALL_CNT_EN
    , .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  assign sram_dq_in = mem[sram_addr];

  // SRAM model: a strobed halfword is stored only when the strobe is followed by a driven hold cycle.
  always @(negedge clk) begin
    if (rst) begin
      pend = 1'b0;
    end else if (!sram_we_n) begin
      we_cnt[sram_addr] = we_cnt[sram_addr] + 1;
      pend = 1'b1;
    end else begin
      if (pend && sram_dq_oe) mem[sram_addr] = sram_dq_out;
      pend = 1'b0;
    end
  end

  function automatic logic [15:0] init_hw(int i);
    return 16'(i * 40503) ^ 16'h5A5A;
  endfunction

  function automatic int word_idx(logic [31:0] a);
    return int'((a >> 2) & 32'h1_FFFF);
  endfunction

  function automatic logic [31:0] ref_read(logic [31:0] a);
    int idx = word_idx(a);
    if (ref_word.exists(idx)) return ref_word[idx];
    return {init_hw(2 * idx + 1), init_hw(2 * idx)};
  endfunction

  task automatic do_access(input bit wr, input logic [31:0] a, input logic [31:0] d,
                           output int lat, output logic [31:0] rd,
                           output logic [17:0] alo, output logic [17:0] ahi);
    @(posedge clk); #1;
    mem_read = !wr; mem_write = wr; address = a; write_data = d;
    lat = -1; rd = 'x; alo = 'x; ahi = 'x;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (c == 1) alo = sram_addr;
      if (c == W + 1) ahi = sram_addr;
      if (ready) begin
        lat = c; rd = read_data;
        break;
      end
      if (c == 3) begin address = $urandom; write_data = $urandom; end
    end
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", ready); end
    n_cmp++; if (sram_we_n !== 1'b1) begin n_bad++; $display("FAIL reset_we_n: got %b want 1", sram_we_n); end
    n_cmp++; if (sram_dq_oe !== 1'b0) begin n_bad++; $display("FAIL reset_oe: got %b want 0", sram_dq_oe); end
    n_cmp++; if (read_data !== 32'h0) begin n_bad++; $display("FAIL reset_read_data: got %h want 0", read_data); end
    n_cmp++; if (sram_addr !== 18'h0) begin n_bad++; $display("FAIL reset_sram_addr: got %h want 0", sram_addr); end
  endtask

  task automatic test_read();
    int lat; logic [31:0] rd; logic [17:0] alo, ahi;
    mem[18'h204] = 16'hBEEF; mem[18'h205] = 16'hDEAD;
    ref_word[32'h102] = 32'hDEAD_BEEF;
    do_access(1'b0, 32'h0000_0408, 32'h0, lat, rd, alo, ahi);
    n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL read_latency: got %0d want %0d", lat, LAT); end
    n_cmp++; if (rd !== ref_read(32'h408)) begin n_bad++; $display("FAIL read_data: got %h want %h", rd, ref_read(32'h408)); end
    n_cmp++; if (alo !== 18'h204) begin n_bad++; $display("FAIL read_addr_lo: got %h want 204", alo); end
    n_cmp++; if (ahi !== 18'h205) begin n_bad++; $display("FAIL read_addr_hi: got %h want 205", ahi); end
    go_idle();
  endtask

  task automatic test_write();
    int lat, c8, c9; logic [31:0] rd, prev; logic [17:0] alo, ahi;
    prev = read_data; c8 = we_cnt[8]; c9 = we_cnt[9];
    do_access(1'b1, 32'h10, 32'h1234_5678, lat, rd, alo, ahi);
    ref_word[4] = 32'h1234_5678;
    n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL write_latency: got %0d want %0d", lat, LAT); end
    n_cmp++; if (alo !== 18'h8 || ahi !== 18'h9) begin n_bad++; $display("FAIL write_addr: got %h/%h want 8/9", alo, ahi); end
    n_cmp++; if (we_cnt[8] - c8 != W - 1 || we_cnt[9] - c9 != W - 1) begin
      n_bad++; $display("FAIL write_strobes: got %0d/%0d want %0d", we_cnt[8] - c8, we_cnt[9] - c9, W - 1); end
    n_cmp++; if ({mem[9], mem[8]} !== ref_read(32'h10)) begin n_bad++; $display("FAIL write_mem: got %h want %h", {mem[9], mem[8]}, ref_read(32'h10)); end
    n_cmp++; if (rd !== prev) begin n_bad++; $display("FAIL write_keeps_read_data: got %h want %h", rd, prev); end
    go_idle();
    @(negedge clk);
    n_cmp++; if (sram_addr !== 18'h9) begin n_bad++; $display("FAIL idle_addr_hold: got %h want 9", sram_addr); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] rd, a, b, d; logic [17:0] alo, ahi;
    a = $urandom; b = $urandom; d = $urandom;
    if (word_idx(a) == word_idx(b)) b = b ^ 32'h40;
    do_access(1'b0, a, 32'h0, lat, rd, alo, ahi);
    n_cmp++; if (lat !== LAT || rd !== ref_read(a)) begin n_bad++; $display("FAIL b2b_read: got %0d/%h want %0d/%h", lat, rd, LAT, ref_read(a)); end
    do_access(1'b1, b, d, lat, rd, alo, ahi);
    ref_word[word_idx(b)] = d;
    n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL b2b_write_latency: got %0d want %0d", lat, LAT); end
    n_cmp++; if ({mem[2 * word_idx(b) + 1], mem[2 * word_idx(b)]} !== d) begin
      n_bad++; $display("FAIL b2b_write_mem: got %h want %h", {mem[2 * word_idx(b) + 1], mem[2 * word_idx(b)]}, d); end
    go_idle();
  endtask

  task automatic test_random();
    int lat; logic [31:0] rd, a, d, prev; logic [17:0] alo, ahi; bit wr;
    for (int i = 0; i < 24; i++) begin
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) a = $urandom;
      else a = ($urandom & 32'hFFF8_0000) | (32'($urandom_range(0, 7)) << 2) | ($urandom & 32'h3);
      d = $urandom;
      prev = read_data;
      do_access(wr, a, d, lat, rd, alo, ahi);
      n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL rand_latency[%0d]: got %0d want %0d", i, lat, LAT); end
      n_cmp++; if (alo !== 18'(2 * word_idx(a)) || ahi !== 18'(2 * word_idx(a) + 1)) begin
        n_bad++; $display("FAIL rand_addr[%0d]: got %h/%h want %h", i, alo, ahi, 2 * word_idx(a)); end
      if (wr) begin
        ref_word[word_idx(a)] = d;
        n_cmp++; if ({mem[2 * word_idx(a) + 1], mem[2 * word_idx(a)]} !== d || rd !== prev) begin
          n_bad++; $display("FAIL rand_write[%0d]: got %h rd %h want %h rd %h", i, {mem[2 * word_idx(a) + 1], mem[2 * word_idx(a)]}, rd, d, prev); end
      end else begin
        n_cmp++; if (rd !== ref_read(a)) begin n_bad++; $display("FAIL rand_read[%0d]: got %h want %h", i, rd, ref_read(a)); end
      end
      if ($urandom_range(0, 2) == 0) go_idle();
    end
    go_idle();
  endtask

  task automatic test_reset_mid_write();
    int lat; logic [31:0] rd, old; logic [17:0] alo, ahi; logic [15:0] old_hi; int c9;
    old = ref_read(32'h10); old_hi = mem[9];
    @(posedge clk); #1;
    mem_write = 1'b1; address = 32'h10; write_data = 32'hCAFE_F00D;
    repeat (8) @(posedge clk);
    #1 rst = 1'b1; mem_write = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    c9 = we_cnt[9];
    n_cmp++; if (ready !== 1'b1 || sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) begin
      n_bad++; $display("FAIL abort_outputs: got rdy %b we_n %b oe %b want 1 1 0", ready, sram_we_n, sram_dq_oe); end
    n_cmp++; if (mem[9] !== old_hi) begin n_bad++; $display("FAIL abort_hi_unwritten: got %h want %h", mem[9], old_hi); end
    repeat (3) @(negedge clk);
    n_cmp++; if (we_cnt[9] != c9) begin n_bad++; $display("FAIL abort_no_strobe: got %0d want %0d", we_cnt[9], c9); end
    ref_word[4] = {old[31:16], 16'hF00D};
    do_access(1'b0, 32'h10, 32'h0, lat, rd, alo, ahi);
    n_cmp++; if (rd !== ref_read(32'h10)) begin n_bad++; $display("FAIL abort_readback: got %h want %h", rd, ref_read(32'h10)); end
    go_idle();
  endtask

`ifdef SRAM_STALL_CNT_EN
  task automatic test_stall_count();
    int lat; logic [31:0] rd; logic [17:0] alo, ahi;
    do_reset();
    @(negedge clk);
    n_cmp++; if (stall_count !== 32'd0) begin n_bad++; $display("FAIL stall_reset: got %0d want 0", stall_count); end
    do_access(1'b0, $urandom, 32'h0, lat, rd, alo, ahi);
    do_access(1'b0, $urandom, 32'h0, lat, rd, alo, ahi);
    go_idle();
    @(negedge clk);
    n_cmp++; if (stall_count !== 32'(2 * LAT)) begin n_bad++; $display("FAIL stall_count: got %0d want %0d", stall_count, 2 * LAT); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 262144; i++) begin
      mem[i] = init_hw(i);
      we_cnt[i] = 0;
    end
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_random();
    test_reset_mid_write();
`ifdef SRAM_STALL_CNT_EN
    test_stall_count();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
